// File: rtl/csi2_rx_lane_ctrl_pkg.sv
// Shared definitions for the CSI-2 receive lane controller: state encodings,
// default timing constants and the per-state lane output decode.
package csi2_rx_lane_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  localparam int unsigned DEF_N_LANES   = 2;
  localparam int unsigned DEF_T_INIT    = 10000;
  localparam int unsigned DEF_T_STOP_TO = 20000;
  localparam int unsigned DEF_T_SETTLE  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF       = 3'd0,
    ST_POWERUP   = 3'd1,
    ST_WAIT_STOP = 3'd2,
    ST_IDLE      = 3'd3,
    ST_CLK_HS    = 3'd4,
    ST_ACTIVE    = 3'd5,
    ST_ULPS      = 3'd6,
    ST_ERROR     = 3'd7
  } lane_state_e;

  typedef struct packed {
    logic clk_shutdown;
    logic data_shutdown;
    logic data_rx_en;
    logic link_up;
  } lane_out_t;

  // Lane pin levels implied by a state; lanes are powered everywhere except OFF/ERROR.
  function automatic lane_out_t state_outputs(input lane_state_e s);
    lane_out_t o;
    o.clk_shutdown  = (s == ST_OFF) || (s == ST_ERROR);
    o.data_shutdown = (s == ST_OFF) || (s == ST_ERROR);
    o.data_rx_en    = (s == ST_ACTIVE);
    o.link_up       = (s == ST_IDLE) || (s == ST_CLK_HS) ||
                      (s == ST_ACTIVE) || (s == ST_ULPS);
    return o;
  endfunction

endpackage

// File: rtl/csi2_rx_timer.sv
// Clearable saturating up-counter with a match flag against a runtime limit.
module csi2_rx_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic             match_c
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (count_q != {WIDTH{1'b1}}) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_c = (count_q == limit);

endmodule

// File: rtl/csi2_rx_lane_ctrl.sv
// D-PHY receive lane power/state sequencer: power-up, stop detection, HS entry,
// ULPS and error recovery for one clock lane plus N_LANES data lanes.
module csi2_rx_lane_ctrl
  import csi2_rx_lane_ctrl_pkg::*;
#(
  parameter int unsigned N_LANES   = DEF_N_LANES,
  parameter int unsigned T_INIT    = DEF_T_INIT,
  parameter int unsigned T_STOP_TO = DEF_T_STOP_TO,
  parameter int unsigned T_SETTLE  = DEF_T_SETTLE
) (
  input  logic               SysClk,
  input  logic               Reset,
  input  logic               Enable,
  input  logic               ClkStopstate,
  input  logic               ClkActiveHs,
  input  logic               ClkUlpm,
  input  logic [N_LANES-1:0] DataStopstate,
  output logic               ClkShutdown,
  output logic [N_LANES-1:0] DataShutdown,
  output logic               DataRxEn,
  output logic               LinkUp,
  output logic               ErrTimeout,
  output logic               ErrClkLoss,
  output logic [STATE_W-1:0] State
);

  localparam int unsigned T_MAX = (T_INIT > T_STOP_TO) ? T_INIT : T_STOP_TO;
  localparam int unsigned TMR_W = $clog2(T_MAX + 1);

  lane_state_e      state_q, state_d;
  lane_out_t        out_q, out_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_clk_loss_q, err_clk_loss_d;
  logic [TMR_W-1:0] tmr_limit_c;
  logic             tmr_match_c;
  logic             tmr_clr_c;
  logic             all_data_stop_c;

  assign all_data_stop_c = &DataStopstate;

  // Each timed state compares against its own terminal count.
  always_comb begin
    tmr_limit_c = '0;
    case (state_q)
      ST_POWERUP:   tmr_limit_c = TMR_W'(T_INIT - 1);
      ST_WAIT_STOP: tmr_limit_c = TMR_W'(T_STOP_TO - 1);
      ST_CLK_HS:    tmr_limit_c = TMR_W'(T_SETTLE - 1);
      default:      tmr_limit_c = '0;
    endcase
  end

  assign tmr_clr_c = (state_d != state_q);

  csi2_rx_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk     (SysClk),
    .rst     (Reset),
    .clr     (tmr_clr_c),
    .limit   (tmr_limit_c),
    .match_c (tmr_match_c)
  );

  always_comb begin
    state_d        = state_q;
    err_timeout_d  = err_timeout_q;
    err_clk_loss_d = err_clk_loss_q;

    if (!Enable) begin
      state_d        = ST_OFF;
      err_timeout_d  = 1'b0;
      err_clk_loss_d = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_POWERUP;
        ST_POWERUP: begin
          if (tmr_match_c) state_d = ST_WAIT_STOP;
        end
        ST_WAIT_STOP: begin
          if (ClkStopstate && all_data_stop_c) begin
            state_d = ST_IDLE;
          end else if (tmr_match_c) begin
            state_d       = ST_ERROR;
            err_timeout_d = 1'b1;
          end
        end
        ST_IDLE: begin
          if (ClkActiveHs) begin
            state_d = ST_CLK_HS;
          end else if (ClkUlpm) begin
            state_d = ST_ULPS;
          end
        end
        ST_CLK_HS: begin
          if (!ClkActiveHs) begin
            state_d = ST_IDLE;
          end else if (tmr_match_c) begin
            state_d = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (!ClkActiveHs) begin
            if (all_data_stop_c) begin
              state_d = ST_IDLE;
            end else begin
              state_d        = ST_ERROR;
              err_clk_loss_d = 1'b1;
            end
          end
        end
        ST_ULPS: begin
          if (!ClkUlpm) state_d = ST_WAIT_STOP;
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_OFF;
      endcase
    end

    out_d = state_outputs(state_d);
  end

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state_q        <= ST_OFF;
      out_q          <= state_outputs(ST_OFF);
      err_timeout_q  <= 1'b0;
      err_clk_loss_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_q          <= out_d;
      err_timeout_q  <= err_timeout_d;
      err_clk_loss_q <= err_clk_loss_d;
    end
  end

  assign ClkShutdown  = out_q.clk_shutdown;
  assign DataShutdown = {N_LANES{out_q.data_shutdown}};
  assign DataRxEn     = out_q.data_rx_en;
  assign LinkUp       = out_q.link_up;
  assign ErrTimeout   = err_timeout_q;
  assign ErrClkLoss   = err_clk_loss_q;
  assign State        = state_q;

endmodule

// File: tb/tb_csi2_rx_lane_ctrl.sv
// Directed bench for csi2_rx_lane_ctrl with short sim timing constants.
module tb_csi2_rx_lane_ctrl;

  localparam int unsigned N_LANES   = 2;
  localparam int unsigned T_INIT    = 50;
  localparam int unsigned T_STOP_TO = 100;
  localparam int unsigned T_SETTLE  = 8;

  logic               clk;
  logic               rst;
  logic               enable;
  logic               clk_stop;
  logic               clk_hs;
  logic               clk_ulpm;
  logic [N_LANES-1:0] data_stop;
  logic               clk_sd;
  logic [N_LANES-1:0] data_sd;
  logic               rx_en;
  logic               link_up;
  logic               err_to;
  logic               err_cl;
  logic [2:0]         state;

  int total = 0;
  int bad   = 0;

  csi2_rx_lane_ctrl #(
    .N_LANES   (N_LANES),
    .T_INIT    (T_INIT),
    .T_STOP_TO (T_STOP_TO),
    .T_SETTLE  (T_SETTLE)
  ) dut (
    .SysClk        (clk),
    .Reset         (rst),
    .Enable        (enable),
    .ClkStopstate  (clk_stop),
    .ClkActiveHs   (clk_hs),
    .ClkUlpm       (clk_ulpm),
    .DataStopstate (data_stop),
    .ClkShutdown   (clk_sd),
    .DataShutdown  (data_sd),
    .DataRxEn      (rx_en),
    .LinkUp        (link_up),
    .ErrTimeout    (err_to),
    .ErrClkLoss    (err_cl),
    .State         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    clk_stop  = 1'b1;
    clk_hs    = 1'b0;
    clk_ulpm  = 1'b0;
    data_stop = 2'b11;
    step(2);
    rst = 1'b0;
  endtask

  // Reset then bring the link to IDLE: 1 cycle to POWERUP, 50 in POWERUP, 1 in WAIT_STOP.
  task automatic bring_up();
    apply_reset();
    enable = 1'b1;
    step(1 + T_INIT + 1);
    total++;
    if (state !== 3'd3) begin
      bad++;
      $display("FAIL bring_up_idle: state=%0d expected=3", state);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (state !== 3'd0 || clk_sd !== 1'b1 || data_sd !== 2'b11 || rx_en !== 1'b0 ||
        link_up !== 1'b0 || err_to !== 1'b0 || err_cl !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: state=%0d clk_sd=%b data_sd=%b rx_en=%b link=%b eto=%b ecl=%b expected 0,1,11,0,0,0,0",
               state, clk_sd, data_sd, rx_en, link_up, err_to, err_cl);
    end
  endtask

  task automatic test_powerup();
    apply_reset();
    enable = 1'b1;
    step(1);
    total++;
    if (state !== 3'd1 || clk_sd !== 1'b0 || data_sd !== 2'b00 || link_up !== 1'b0) begin
      bad++;
      $display("FAIL powerup_entry: state=%0d clk_sd=%b data_sd=%b link=%b expected 1,0,00,0",
               state, clk_sd, data_sd, link_up);
    end
    step(T_INIT - 1);
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL powerup_hold: state=%0d expected=1", state);
    end
    step(1);
    total++;
    if (state !== 3'd2 || link_up !== 1'b0) begin
      bad++;
      $display("FAIL powerup_exit: state=%0d link=%b expected 2,0", state, link_up);
    end
    step(1);
    total++;
    if (state !== 3'd3 || link_up !== 1'b1 || clk_sd !== 1'b0) begin
      bad++;
      $display("FAIL stop_to_idle: state=%0d link=%b clk_sd=%b expected 3,1,0", state, link_up, clk_sd);
    end
  endtask

  task automatic test_hs_active();
    bring_up();
    clk_hs = 1'b1;
    step(T_SETTLE);
    total++;
    if (state !== 3'd4 || rx_en !== 1'b0) begin
      bad++;
      $display("FAIL clk_hs_settle: state=%0d rx_en=%b expected 4,0", state, rx_en);
    end
    step(1);
    total++;
    if (state !== 3'd5 || rx_en !== 1'b1) begin
      bad++;
      $display("FAIL active_entry: state=%0d rx_en=%b expected 5,1", state, rx_en);
    end
    clk_hs    = 1'b0;
    data_stop = 2'b11;
    step(1);
    total++;
    if (state !== 3'd3 || rx_en !== 1'b0 || err_cl !== 1'b0 || err_to !== 1'b0) begin
      bad++;
      $display("FAIL active_to_idle: state=%0d rx_en=%b ecl=%b eto=%b expected 3,0,0,0",
               state, rx_en, err_cl, err_to);
    end
  endtask

  task automatic test_clk_loss();
    bring_up();
    clk_hs = 1'b1;
    step(T_SETTLE + 1);
    clk_hs    = 1'b0;
    data_stop = 2'b01;
    step(1);
    total++;
    if (state !== 3'd7 || err_cl !== 1'b1 || clk_sd !== 1'b1 || data_sd !== 2'b11 ||
        rx_en !== 1'b0 || link_up !== 1'b0) begin
      bad++;
      $display("FAIL clk_loss_error: state=%0d ecl=%b clk_sd=%b data_sd=%b rx_en=%b link=%b expected 7,1,1,11,0,0",
               state, err_cl, clk_sd, data_sd, rx_en, link_up);
    end
    data_stop = 2'b11;
    clk_stop  = 1'b1;
    step(5);
    total++;
    if (state !== 3'd7 || err_cl !== 1'b1) begin
      bad++;
      $display("FAIL error_hold: state=%0d ecl=%b expected 7,1", state, err_cl);
    end
    enable = 1'b0;
    step(1);
    total++;
    if (state !== 3'd0 || err_cl !== 1'b0 || clk_sd !== 1'b1) begin
      bad++;
      $display("FAIL error_clear: state=%0d ecl=%b clk_sd=%b expected 0,0,1", state, err_cl, clk_sd);
    end
  endtask

  task automatic test_stop_timeout(input bit late_stop);
    apply_reset();
    enable    = 1'b1;
    data_stop = 2'b10;
    step(1 + T_INIT);
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL wait_stop_entry: state=%0d expected=2", state);
    end
    step(T_STOP_TO - 1);
    total++;
    if (state !== 3'd2 || err_to !== 1'b0) begin
      bad++;
      $display("FAIL wait_stop_hold: state=%0d eto=%b expected 2,0", state, err_to);
    end
    if (late_stop) data_stop = 2'b11;
    step(1);
    if (late_stop) begin
      total++;
      if (state !== 3'd3 || err_to !== 1'b0) begin
        bad++;
        $display("FAIL late_stop_wins: state=%0d eto=%b expected 3,0", state, err_to);
      end
    end else begin
      total++;
      if (state !== 3'd7 || err_to !== 1'b1 || clk_sd !== 1'b1) begin
        bad++;
        $display("FAIL stop_timeout: state=%0d eto=%b clk_sd=%b expected 7,1,1", state, err_to, clk_sd);
      end
    end
  endtask

  task automatic test_glitch_ulps();
    bring_up();
    clk_hs = 1'b1;
    step(1);
    step(3);
    total++;
    if (state !== 3'd4 || rx_en !== 1'b0) begin
      bad++;
      $display("FAIL glitch_pre: state=%0d rx_en=%b expected 4,0", state, rx_en);
    end
    clk_hs = 1'b0;
    step(1);
    total++;
    if (state !== 3'd3 || rx_en !== 1'b0) begin
      bad++;
      $display("FAIL glitch_idle: state=%0d rx_en=%b expected 3,0", state, rx_en);
    end
    clk_ulpm = 1'b1;
    step(1);
    total++;
    if (state !== 3'd6 || link_up !== 1'b1 || clk_sd !== 1'b0) begin
      bad++;
      $display("FAIL ulps_entry: state=%0d link=%b clk_sd=%b expected 6,1,0", state, link_up, clk_sd);
    end
    clk_ulpm = 1'b0;
    step(1);
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL ulps_wake: state=%0d expected=2", state);
    end
    step(1);
    total++;
    if (state !== 3'd3) begin
      bad++;
      $display("FAIL wake_idle: state=%0d expected=3", state);
    end
    clk_hs   = 1'b1;
    clk_ulpm = 1'b1;
    step(1);
    total++;
    if (state !== 3'd4) begin
      bad++;
      $display("FAIL hs_over_ulps: state=%0d expected=4", state);
    end
    clk_hs   = 1'b0;
    clk_ulpm = 1'b0;
  endtask

  task automatic test_reset_and_disable();
    bring_up();
    clk_hs = 1'b1;
    step(T_SETTLE + 1);
    total++;
    if (state !== 3'd5) begin
      bad++;
      $display("FAIL pre_reset_active: state=%0d expected=5", state);
    end
    rst = 1'b1;
    step(1);
    total++;
    if (state !== 3'd0 || clk_sd !== 1'b1 || data_sd !== 2'b11 || rx_en !== 1'b0 ||
        link_up !== 1'b0 || err_to !== 1'b0 || err_cl !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: state=%0d clk_sd=%b data_sd=%b rx_en=%b link=%b eto=%b ecl=%b expected 0,1,11,0,0,0,0",
               state, clk_sd, data_sd, rx_en, link_up, err_to, err_cl);
    end
    rst    = 1'b0;
    clk_hs = 1'b0;
    step(1);
    total++;
    if (state !== 3'd1 || clk_sd !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_powerup: state=%0d clk_sd=%b expected 1,0", state, clk_sd);
    end
    step(10);
    enable = 1'b0;
    step(1);
    total++;
    if (state !== 3'd0 || clk_sd !== 1'b1 || data_sd !== 2'b11) begin
      bad++;
      $display("FAIL disable_powerup: state=%0d clk_sd=%b data_sd=%b expected 0,1,11", state, clk_sd, data_sd);
    end
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    clk_stop  = 1'b1;
    clk_hs    = 1'b0;
    clk_ulpm  = 1'b0;
    data_stop = 2'b11;
    test_reset();
    test_powerup();
    test_hs_active();
    test_clk_loss();
    test_stop_timeout(1'b0);
    test_stop_timeout(1'b1);
    test_glitch_ulps();
    test_reset_and_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
